// File: rtl/register_writeback_stage.sv
// rtl/register_writeback_stage.sv - writeback stage selecting ALU/link/load data into the register file
//
// Sits between execute/memory and the register file. Non-load requests are
// written one cycle after acceptance; loads park in WAIT_MEM until the memory
// returns data, which is aligned and extended before the write.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   in_valid / in_ready       request handshake (ready only in IDLE)
//   in_sel, in_we, in_rd      source select (0 ALU, 1 link, 2 DMEM, 3 zero), write enable, destination
//   in_alu_out, in_link_pc    candidate write data
//   in_ld_size/signed/off     load width, extension and byte offset
//   mem_rvalid, mem_rdata     load data return (one-cycle pulse, aligned word)
//   rf_we, rf_waddr, rf_wdata registered register file write port
//   pending_valid/pending_rd  outstanding load destination for hazard stalls
//   wb_err                    one-cycle pulse when a load times out and is dropped
module register_writeback_stage #(
    parameter int DATA_W      = 32,
    parameter int PC_W        = 16,
    parameter int RADDR_W     = 4,
    parameter int ZERO_REG    = 1,
    parameter int MEM_TIMEOUT = 0,
    localparam int OFF_W      = $clog2(DATA_W / 8)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [1:0]         in_sel,
    input  logic               in_we,
    input  logic [RADDR_W-1:0] in_rd,
    input  logic [DATA_W-1:0]  in_alu_out,
    input  logic [PC_W-1:0]    in_link_pc,
    input  logic [1:0]         in_ld_size,
    input  logic               in_ld_signed,
    input  logic [OFF_W-1:0]   in_ld_off,
    input  logic               mem_rvalid,
    input  logic [DATA_W-1:0]  mem_rdata,
    output logic               rf_we,
    output logic [RADDR_W-1:0] rf_waddr,
    output logic [DATA_W-1:0]  rf_wdata,
    output logic               pending_valid,
    output logic [RADDR_W-1:0] pending_rd,
    output logic               wb_err
);

    localparam int CNT_W        = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
    localparam int TMO_LAST_I   = (MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0;
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TMO_LAST_I);

    typedef enum logic [0:0] {IDLE, WAIT_MEM} state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [RADDR_W-1:0]  cap_rd_q;
    logic [1:0]          cap_size_q;
    logic                cap_signed_q;
    logic [OFF_W-1:0]    cap_off_q;

    logic                capture;
    logic                wr_upd;
    logic                wr_en;
    logic [RADDR_W-1:0]  wr_addr;
    logic [DATA_W-1:0]   wr_data;
    logic                err_d;

    logic [DATA_W-1:0]   link_ext;
    logic [DATA_W-1:0]   sel_data;
    logic [OFF_W-1:0]    off_eff;
    logic [DATA_W-1:0]   lane;
    logic [DATA_W-1:0]   ld_data;

    logic accept;
    logic is_load;

    assign in_ready      = (state_q == IDLE);
    assign accept        = in_valid & in_ready;
    assign is_load       = (in_sel == 2'd2) & in_we;
    assign pending_valid = (state_q == WAIT_MEM);
    assign pending_rd    = pending_valid ? cap_rd_q : '0;

    if (PC_W >= DATA_W) begin : g_link_trunc
        assign link_ext = in_link_pc[DATA_W-1:0];
    end else begin : g_link_zext
        assign link_ext = {{(DATA_W - PC_W){1'b0}}, in_link_pc};
    end

    always_comb begin
        sel_data = '0;
        case (in_sel)
            2'd0:    sel_data = in_alu_out;
            2'd1:    sel_data = link_ext;
            default: sel_data = '0;
        endcase
    end

    // Word loads use offset 0 so the full shifted lane is the result.
    always_comb begin
        off_eff = cap_off_q;
        if (cap_size_q == 2'd1) begin
            off_eff[0] = 1'b0;
        end else if (cap_size_q[1]) begin
            off_eff = '0;
        end
        lane    = mem_rdata >> {off_eff, 3'b000};
        ld_data = lane;
        case (cap_size_q)
            2'd0:    ld_data = {{(DATA_W - 8){cap_signed_q & lane[7]}}, lane[7:0]};
            2'd1:    ld_data = {{(DATA_W - 16){cap_signed_q & lane[15]}}, lane[15:0]};
            default: ld_data = lane;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        capture = 1'b0;
        wr_upd  = 1'b0;
        wr_en   = 1'b0;
        wr_addr = in_rd;
        wr_data = sel_data;
        err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (is_load) begin
                        capture = 1'b1;
                        cnt_d   = '0;
                        state_d = WAIT_MEM;
                    end else begin
                        wr_upd = 1'b1;
                        wr_en  = in_we & ~((ZERO_REG != 0) && (in_rd == '0));
                    end
                end
            end
            WAIT_MEM: begin
                cnt_d = cnt_q + CNT_W'(1);
                // Returning data takes priority over an expiry in the same cycle.
                if (mem_rvalid) begin
                    wr_upd  = 1'b1;
                    wr_en   = ~((ZERO_REG != 0) && (cap_rd_q == '0));
                    wr_addr = cap_rd_q;
                    wr_data = ld_data;
                    state_d = IDLE;
                end else if ((MEM_TIMEOUT > 0) && (cnt_q == TMO_LAST)) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            cap_rd_q     <= '0;
            cap_size_q   <= '0;
            cap_signed_q <= 1'b0;
            cap_off_q    <= '0;
            rf_we        <= 1'b0;
            rf_waddr     <= '0;
            rf_wdata     <= '0;
            wb_err       <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rf_we   <= wr_en;
            wb_err  <= err_d;
            if (capture) begin
                cap_rd_q     <= in_rd;
                cap_size_q   <= in_ld_size;
                cap_signed_q <= in_ld_signed;
                cap_off_q    <= in_ld_off;
            end
            if (wr_upd) begin
                rf_waddr <= wr_addr;
                rf_wdata <= wr_data;
            end
        end
    end

endmodule
